// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the channel-to-capacitor mapping datapath.
// Selection codes at or above the channel count park the output lane at zero.
package mux_pkg;

    localparam int WIDTH_DEF         = 8;
    localparam int CHANNEL_NUM_DEF   = 128;
    localparam int CAPACITOR_NUM_DEF = 70;

    function automatic int sel_width(input int channel_num);
        return $clog2(channel_num + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SEL_W_DEF = sel_width(CHANNEL_NUM_DEF);
    localparam int PARK_SEL  = CHANNEL_NUM_DEF;

endpackage

// File: rtl/cap_map_cfg.sv
// Double-buffered capacitor selection table: shadow writes, atomic commit to the
// active table (a same-cycle write is folded into the commit), sticky address error.
module cap_map_cfg
    import mux_pkg::*;
#(
    parameter int CHANNEL_NUM   = CHANNEL_NUM_DEF,
    parameter int CAPACITOR_NUM = CAPACITOR_NUM_DEF,
    parameter int SEL_W         = sel_width(CHANNEL_NUM),
    parameter int ADDR_W        = idx_width(CAPACITOR_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_wr,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [SEL_W-1:0]           cfg_sel,
    input  logic                       cfg_commit,
    output logic                       cfg_err,
    output logic [SEL_W*CAPACITOR_NUM-1:0] active_sel
);

    logic [SEL_W-1:0] shadow_sel [CAPACITOR_NUM];
    logic [SEL_W-1:0] shadow_nxt [CAPACITOR_NUM];
    logic [SEL_W-1:0] active_q   [CAPACITOR_NUM];
    logic             addr_ok;

    assign addr_ok = (int'(cfg_addr) < CAPACITOR_NUM);

    // shadow_nxt already contains this cycle's write, which gives the commit bypass
    always_comb begin
        for (int k = 0; k < CAPACITOR_NUM; k++) begin
            shadow_nxt[k] = shadow_sel[k];
            if (cfg_wr && addr_ok && (int'(cfg_addr) == k)) begin
                shadow_nxt[k] = cfg_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CAPACITOR_NUM; k++) begin
                shadow_sel[k] <= SEL_W'(k);
                active_q[k]   <= SEL_W'(k);
            end
            cfg_err <= 1'b0;
        end else begin
            for (int k = 0; k < CAPACITOR_NUM; k++) begin
                shadow_sel[k] <= shadow_nxt[k];
                if (cfg_commit) begin
                    active_q[k] <= shadow_nxt[k];
                end
            end
            if (cfg_wr && !addr_ok) begin
                cfg_err <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < CAPACITOR_NUM; k++) begin : g_pack
        assign active_sel[k*SEL_W +: SEL_W] = active_q[k];
    end

endmodule

// File: rtl/cap_map_pipe.sv
// Two-stage channel-to-capacitor lane mapper: input register, then table-driven
// lane mux with registered output data and per-lane all-zero / all-one flags.
module cap_map_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int CHANNEL_NUM   = CHANNEL_NUM_DEF,
    parameter int CAPACITOR_NUM = CAPACITOR_NUM_DEF,
    parameter int SEL_W         = sel_width(CHANNEL_NUM),
    parameter int ADDR_W        = idx_width(CAPACITOR_NUM)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [WIDTH*CHANNEL_NUM-1:0]   data_in,
    input  logic                           cfg_wr,
    input  logic [ADDR_W-1:0]              cfg_addr,
    input  logic [SEL_W-1:0]               cfg_sel,
    input  logic                           cfg_commit,
    output logic                           cfg_err,
    output logic                           out_valid,
    output logic [WIDTH*CAPACITOR_NUM-1:0] data_out,
    output logic [CAPACITOR_NUM-1:0]       out_zero,
    output logic [CAPACITOR_NUM-1:0]       out_ones
);

    localparam int IDX_W = idx_width(CHANNEL_NUM);

    if (CAPACITOR_NUM > CHANNEL_NUM || WIDTH < 1) begin : g_param_err
        $error("cap_map_pipe: CAPACITOR_NUM must not exceed CHANNEL_NUM and WIDTH must be >= 1");
    end

    logic [SEL_W*CAPACITOR_NUM-1:0] active_sel;
    logic [WIDTH*CHANNEL_NUM-1:0]   s0_data;
    logic                           s0_valid;
    logic [WIDTH-1:0]               s0_lane [CHANNEL_NUM];
    logic [WIDTH*CAPACITOR_NUM-1:0] lane_mux;
    logic [CAPACITOR_NUM-1:0]       zero_nxt;
    logic [CAPACITOR_NUM-1:0]       ones_nxt;

    cap_map_cfg #(
        .CHANNEL_NUM   (CHANNEL_NUM),
        .CAPACITOR_NUM (CAPACITOR_NUM),
        .SEL_W         (SEL_W),
        .ADDR_W        (ADDR_W)
    ) u_cfg (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_sel    (cfg_sel),
        .cfg_commit (cfg_commit),
        .cfg_err    (cfg_err),
        .active_sel (active_sel)
    );

    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_unpack
        assign s0_lane[i] = s0_data[i*WIDTH +: WIDTH];
    end

    for (genvar k = 0; k < CAPACITOR_NUM; k++) begin : g_lane
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] lane;
        assign sel         = active_sel[k*SEL_W +: SEL_W];
        assign lane        = (int'(sel) < CHANNEL_NUM) ? s0_lane[sel[IDX_W-1:0]] : '0;
        assign lane_mux[k*WIDTH +: WIDTH] = lane;
        assign zero_nxt[k] = (lane == '0);
        assign ones_nxt[k] = &lane;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_data   <= '0;
            s0_valid  <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_zero  <= '0;
            out_ones  <= '0;
        end else begin
            s0_data   <= data_in;
            s0_valid  <= in_valid;
            out_valid <= s0_valid;
            // flags stay paired with the held data word
            if (s0_valid) begin
                data_out <= lane_mux;
                out_zero <= zero_nxt;
                out_ones <= ones_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cap_map_pipe.sv
// Randomised scoreboard bench for cap_map_pipe: a table-level model predicts each
// mapped lane-set at issue time, and a monitor checks it when out_valid shows it.
module tb_cap_map_pipe;
    import mux_pkg::*;

    localparam int W   = WIDTH_DEF;
    localparam int CH  = CHANNEL_NUM_DEF;
    localparam int CAP = CAPACITOR_NUM_DEF;
    localparam int SW  = sel_width(CH);
    localparam int AW  = idx_width(CAP);

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [W*CH-1:0]    data_in;
    logic               cfg_wr;
    logic [AW-1:0]      cfg_addr;
    logic [SW-1:0]      cfg_sel;
    logic               cfg_commit;
    logic               cfg_err;
    logic               out_valid;
    logic [W*CAP-1:0]   data_out;
    logic [CAP-1:0]     out_zero;
    logic [CAP-1:0]     out_ones;

    cap_map_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_sel    (cfg_sel),
        .cfg_commit (cfg_commit),
        .cfg_err    (cfg_err),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .out_zero   (out_zero),
        .out_ones   (out_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm, input string act, input string exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [W*CAP-1:0] data;
        logic [CAP-1:0]   zero;
        logic [CAP-1:0]   ones;
        int               cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [W-1:0] lanes [CH];
    int         shadow [CAP];
    int         active [CAP];
    bit         model_err;
    bit         err_seen;

    task automatic model_reset();
        for (int k = 0; k < CAP; k++) begin
            shadow[k] = k;
            active[k] = k;
        end
        model_err = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_seen <= 1'b0;
        else        err_seen <= model_err;
    end

    task automatic compare_set(input string nm, input logic [W*CAP-1:0] ed,
                               input logic [CAP-1:0] ez, input logic [CAP-1:0] eo);
        int bad;
        bad = -1;
        for (int k = CAP - 1; k >= 0; k--) begin
            if (data_out[k*W +: W] !== ed[k*W +: W]) bad = k;
        end
        if (bad < 0) chk(1'b1, nm, "", "");
        else chk(1'b0, {nm, "_data"},
                 $sformatf("lane %0d = %02h", bad, data_out[bad*W +: W]),
                 $sformatf("%02h", ed[bad*W +: W]));
        chk(out_zero === ez, {nm, "_zero"}, $sformatf("%h", out_zero), $sformatf("%h", ez));
        chk(out_ones === eo, {nm, "_ones"}, $sformatf("%h", out_ones), $sformatf("%h", eo));
    endtask

    logic [W*CAP-1:0] last_data;
    logic [CAP-1:0]   last_zero;
    logic [CAP-1:0]   last_ones;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = '0;
            last_zero = '0;
            last_ones = '0;
        end else begin
            chk(cfg_err === err_seen, "cfg_err", $sformatf("%b", cfg_err), $sformatf("%b", err_seen));
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_valid", "out_valid=1", "no pending lane-set");
                end else begin
                    mon_e = sb.pop_front();
                    chk(cyc == mon_e.cyc, "latency", $sformatf("cycle %0d", cyc),
                        $sformatf("cycle %0d", mon_e.cyc));
                    compare_set("map", mon_e.data, mon_e.zero, mon_e.ones);
                    last_data = mon_e.data;
                    last_zero = mon_e.zero;
                    last_ones = mon_e.ones;
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    chk(1'b0, "missing_valid", "out_valid=0", $sformatf("valid at cycle %0d", sb[0].cyc));
                    void'(sb.pop_front());
                end
                compare_set("hold", last_data, last_zero, last_ones);
            end
        end
    end

    // Drive one cycle of stimulus and predict its effect on the tables and outputs.
    task automatic step(input bit v, input bit wr, input int addr, input int sel, input bit commit);
        exp_t e;
        @(negedge clk);
        in_valid   = v;
        for (int i = 0; i < CH; i++) data_in[i*W +: W] = lanes[i];
        cfg_wr     = wr;
        cfg_addr   = AW'(addr);
        cfg_sel    = SW'(sel);
        cfg_commit = commit;
        if (wr) begin
            if (addr < CAP) shadow[addr] = sel;
            else            model_err = 1'b1;
        end
        if (commit) begin
            for (int k = 0; k < CAP; k++) active[k] = shadow[k];
        end
        if (v) begin
            for (int k = 0; k < CAP; k++) begin
                logic [W-1:0] val;
                val = (active[k] < CH) ? lanes[active[k]] : '0;
                e.data[k*W +: W] = val;
                e.zero[k] = (val == '0);
                e.ones[k] = (val == {W{1'b1}});
            end
            e.cyc = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 7))
                0:       lanes[i] = '0;
                1:       lanes[i] = {W{1'b1}};
                default: lanes[i] = W'($urandom_range(0, (1 << W) - 1));
            endcase
        end
    endtask

    task automatic rand_step();
        int sel;
        rand_lanes();
        sel = ($urandom_range(0, 1) == 0) ? $urandom_range(0, CH - 1) : $urandom_range(0, (1 << SW) - 1);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, (1 << AW) - 1), sel, $urandom_range(0, 6) == 0);
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        data_in    = '0;
        cfg_wr     = 1'b0;
        cfg_addr   = '0;
        cfg_sel    = '0;
        cfg_commit = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(out_valid === 1'b0, {nm, "_valid"}, $sformatf("%b", out_valid), "0");
        chk(data_out === '0, {nm, "_data"}, "nonzero data_out", "all zero");
        chk(out_zero === '0, {nm, "_zero"}, $sformatf("%h", out_zero), "0");
        chk(out_ones === '0, {nm, "_ones"}, $sformatf("%h", out_ones), "0");
        chk(cfg_err === 1'b0, {nm, "_err"}, $sformatf("%b", cfg_err), "0");
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        for (int i = 0; i < CH; i++) lanes[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < CH; i++) lanes[i] = W'(i);
        repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0);

        lanes[CH-1] = {W{1'b1}};
        step(1'b1, 1'b1, 5, CH - 1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0);

        step(1'b1, 1'b1, 3, PARK_SEL, 1'b1);
        repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0);

        step(1'b1, 1'b1, CAP, 0, 1'b0);
        step(1'b1, 1'b1, 100, 9, 1'b1);
        repeat (4) step(1'b1, 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 3; n++) begin
            rand_lanes();
            step(n != 1, 1'b0, 0, 0, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0, 0, 0, 1'b0);

        repeat (400) rand_step();

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        sb.delete();
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        rand_lanes();
        repeat (4) step(1'b1, 1'b0, 0, 0, 1'b0);
        repeat (200) rand_step();

        repeat (4) step(1'b0, 1'b0, 0, 0, 1'b0);
        chk(sb.size() == 0, "drain", $sformatf("%0d pending", sb.size()), "0 pending");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
